lfsr_period_monitor: RTL and testbench

- Downstream observer of the lfsr stage. It snoops the same load strobe and the parallel state q.
- After each seed load it captures the seeded state and counts shift cycles until that state recurs, reporting the sequence period.
- Flags lock-up (all-zero state) and timeout (counter exhausted).
- Used in self-test to confirm that tap placement produces the expected sequence length.

---
 rtl/lfsr_period_monitor.sv | 140 ++++++++++++++
 tb/tb_lfsr_period_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_period_monitor
// Description : Measures the sequence period of an observed LFSR after each
//               seed load; flags lock-up and counter timeout. Optional
//               LFSR_PERIOD_MON_ONES_EN adds a ones_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_period_monitor #(
    parameter int N     = 26,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             r,
    input  logic             load,
    input  logic [N-1:0]     q,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic             timeout,
    output logic [CNT_W-1:0] period,
    output logic [N-1:0]     ref_state
`ifdef LFSR_PERIOD_MON_ONES_EN
    ,
    output logic [CNT_W-1:0] ones_count
`endif
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ARMED   = 3'd1;
    localparam logic [2:0] c_ST_RUN     = 3'd2;
    localparam logic [2:0] c_ST_DONE    = 3'd3;
    localparam logic [2:0] c_ST_LOCKUP  = 3'd4;
    localparam logic [2:0] c_ST_TIMEOUT = 3'd5;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [N-1:0]     r_ref;
    logic             w_q_zero;
    logic             w_match;
    logic             w_cnt_max;

    assign w_q_zero  = (q == '0);
    assign w_match   = (q == r_ref);
    assign w_cnt_max = &r_cnt;
    assign period    = r_period;
    assign ref_state = r_ref;

    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Match is tested before zero and the limit so a recurrence always wins.
    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = c_ST_ARMED;
        end else begin
            case (r_state)
                c_ST_ARMED: w_state_nxt = w_q_zero ? c_ST_LOCKUP : c_ST_RUN;
                c_ST_RUN: begin
                    if (w_match) begin
                        w_state_nxt = c_ST_DONE;
                    end else if (w_q_zero) begin
                        w_state_nxt = c_ST_LOCKUP;
                    end else if (w_cnt_max) begin
                        w_state_nxt = c_ST_TIMEOUT;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        lockup  = 1'b0;
        timeout = 1'b0;
        case (r_state)
            c_ST_ARMED,
            c_ST_RUN:     busy    = 1'b1;
            c_ST_DONE:    done    = 1'b1;
            c_ST_LOCKUP:  lockup  = 1'b1;
            c_ST_TIMEOUT: timeout = 1'b1;
            default:      busy    = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_cnt    <= '0;
            r_period <= '0;
            r_ref    <= '0;
        end else if (load) begin
            r_cnt    <= '0;
            r_period <= '0;
        end else if (r_state == c_ST_ARMED) begin
            r_ref <= q;
            if (!w_q_zero) begin
                r_cnt <= c_CNT_ONE;
            end
        end else if (r_state == c_ST_RUN) begin
            if (w_match || w_q_zero || w_cnt_max) begin
                r_period <= r_cnt;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

`ifdef LFSR_PERIOD_MON_ONES_EN
    logic [CNT_W-1:0] r_ones;
    logic [CNT_W-1:0] w_msb_ext;

    assign w_msb_ext  = {{(CNT_W-1){1'b0}}, q[N-1]};
    assign ones_count = r_ones;

    // The sample that ends the measurement is the seed again, so it is not counted.
    always_ff @(posedge clk) begin
        if (r || load) begin
            r_ones <= '0;
        end else if (r_state == c_ST_ARMED) begin
            r_ones <= w_msb_ext;
        end else if (r_state == c_ST_RUN && !(w_match || w_q_zero || w_cnt_max)) begin
            r_ones <= r_ones + w_msb_ext;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_period_monitor
// Description : Scoreboard bench for lfsr_period_monitor (N=4, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_period_monitor;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int LIMIT = (1 << CNT_W) - 1;

    typedef struct {
        logic        done;
        logic        lockup;
        logic        timeout;
        logic [31:0] period;
        logic [31:0] ref_state;
        logic [31:0] ones;
        int          cyc;
    } exp_t;

    logic             clk;
    logic             r;
    logic             load;
    logic [N-1:0]     q;
    logic             busy;
    logic             done;
    logic             lockup;
    logic             timeout;
    logic [CNT_W-1:0] period;
    logic [N-1:0]     ref_state;
`ifdef LFSR_PERIOD_MON_ONES_EN
    logic [CNT_W-1:0] ones_count;
`endif

    int          checks;
    int          failures;
    int          cyc;
    logic        r_q;
    exp_t        exp_q[$];
    logic [N-1:0] stim_q[$];
    logic [31:0] prev_ref;

    lfsr_period_monitor #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .r         (r),
        .load      (load),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .lockup    (lockup),
        .timeout   (timeout),
        .period    (period),
        .ref_state (ref_state)
`ifdef LFSR_PERIOD_MON_ONES_EN
        ,
        .ones_count(ones_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        r_q <= r;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] other(input logic [N-1:0] seed);
        logic [N-1:0] v;
        do v = N'($urandom); while (v == '0 || v == seed);
        return v;
    endfunction

    // Result presented when busy falls outside a reset.
    initial begin : monitor
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_busy && busy === 1'b0 && r_q !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=busy_fell required=no_result");
                end else begin
                    e = exp_q.pop_front();
                    check("done", 32'(done), 32'(e.done));
                    check("lockup", 32'(lockup), 32'(e.lockup));
                    check("timeout", 32'(timeout), 32'(e.timeout));
                    check("period", 32'(period), e.period);
                    check("ref_state", 32'(ref_state), e.ref_state);
                    check("end_cycle", 32'(cyc), 32'(e.cyc));
`ifdef LFSR_PERIOD_MON_ONES_EN
                    check("ones_count", 32'(ones_count), e.ones);
`endif
                end
            end
            prev_busy = (busy === 1'b1);
        end
    end

    // Outcome is derived from the sampled sequence: the k-th post-capture sample ends
    // the run on recurrence, zero, or when k reaches the counter limit.
    task automatic measure(input logic [N-1:0] seed);
        exp_t e;
        int   n_used;
        int   load_edge;
        logic [N-1:0] v;
        e.done = 0; e.lockup = 0; e.timeout = 0; e.period = 0;
        e.ref_state = 32'(seed);
        e.ones = 32'(seed[N-1]);
        n_used = 0;
        if (seed == '0) begin
            e.lockup = 1;
        end else begin
            for (int k = 1; k <= stim_q.size(); k++) begin
                v = stim_q[k-1];
                n_used = k;
                if (v == seed) begin
                    e.done = 1; e.period = 32'(k); break;
                end else if (v == '0) begin
                    e.lockup = 1; e.period = 32'(k); break;
                end else if (k == LIMIT) begin
                    e.timeout = 1; e.period = 32'(k); break;
                end
                e.ones += 32'(v[N-1]);
            end
        end
        @(negedge clk);
        load = 1'b1;
        q = N'($urandom);
        load_edge = cyc + 1;
        @(negedge clk);
        check("load_busy", 32'(busy), 32'd1);
        check("load_flags", {29'd0, done, lockup, timeout}, 32'd0);
        check("load_period", 32'(period), 32'd0);
        check("load_ref_held", 32'(ref_state), prev_ref);
        load = 1'b0;
        q = seed;
        e.cyc = load_edge + 1 + n_used;
        exp_q.push_back(e);
        for (int i = 0; i < n_used; i++) begin
            @(negedge clk);
            q = stim_q[i];
        end
        prev_ref = 32'(seed);
        repeat ($urandom_range(2, 4)) begin
            @(negedge clk);
            q = N'($urandom);
        end
        check("held_busy", 32'(busy), 32'd0);
        check("held_flags", {29'd0, done, lockup, timeout}, {29'd0, e.done, e.lockup, e.timeout});
        check("held_period", 32'(period), e.period);
        check("held_ref", 32'(ref_state), e.ref_state);
    endtask

    task automatic partial(input logic [N-1:0] seed, input int n);
        @(negedge clk);
        load = 1'b1;
        q = N'($urandom);
        @(negedge clk);
        load = 1'b0;
        q = seed;
        prev_ref = 32'(seed);
        repeat (n) begin
            @(negedge clk);
            q = other(seed);
        end
    endtask

    task automatic gen(input int mode, input logic [N-1:0] seed);
        int p;
        stim_q.delete();
        p = $urandom_range(1, LIMIT - 1);
        case (mode)
            0: begin
                repeat (p - 1) stim_q.push_back(other(seed));
                stim_q.push_back(seed);
            end
            1: begin
                repeat (p - 1) stim_q.push_back(other(seed));
                stim_q.push_back('0);
            end
            2: repeat (LIMIT + 1) stim_q.push_back(other(seed));
            default: repeat (LIMIT + 1) stim_q.push_back(N'($urandom));
        endcase
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, lockup, timeout, 12'd0, period, ref_state}, 32'd0);
    endtask

    initial begin : stimulus
        logic [N-1:0] seed;
        checks = 0;
        failures = 0;
        prev_ref = 0;
        r = 1'b1;
        load = 1'b0;
        q = '0;
        repeat (2) begin
            @(negedge clk);
            q = N'($urandom);
            load = 1'($urandom);
        end
        @(negedge clk);
        check_all_zero("reset_state");
`ifdef LFSR_PERIOD_MON_ONES_EN
        check("reset_ones", 32'(ones_count), 32'd0);
`endif
        r = 1'b0;
        load = 1'b0;

        stim_q = '{4'h2, 4'h4, 4'h8, 4'h1};
        measure(4'h1);
        stim_q = '{4'h6, 4'h0};
        measure(4'h3);
        stim_q.delete();
        measure(4'h0);
        stim_q.delete();
        for (int i = 2; i <= LIMIT + 2; i++) stim_q.push_back(N'(((i - 1) % LIMIT) + 1));
        measure(4'h1);
        stim_q = '{4'h9};
        measure(4'h9);
        stim_q.delete();
        repeat (LIMIT - 1) stim_q.push_back(other(4'h5));
        stim_q.push_back(4'h5);
        measure(4'h5);

        partial(4'h7, 4);
        stim_q = '{4'h3, 4'hA, 4'h7};
        measure(4'h7);

        partial(4'hC, 6);
        @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
        check_all_zero("reset_mid_run");
        prev_ref = 0;
        stim_q = '{4'h1, 4'h2, 4'hB};
        measure(4'hB);

        for (int t = 0; t < 48; t++) begin
            seed = N'($urandom_range(1, LIMIT));
            gen(t % 4, seed);
            measure(seed);
        end

        repeat (4) @(negedge clk);
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
